data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Arbitrates between two load/store masters (m0 = core LSU, m1 = program loader/debug port) and sequences their accesses to the single data bus controller.
- Latches one request at a time, drives one-cycle wd/rd strobes, waits for the bus ready/busy handshake, then returns read data and a done/err pulse to the owner.
- Sits between the core datapath and the data bus controller; m0_stall feeds the program-counter enable.

Parameters:
ADDR_WIDTH, 32, address width of masters and bus
DATA_WIDTH, 32, data width of masters and bus
TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with the optional feature

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
m0_req / m1_req  input  1  access request; held until gnt
m0_wr / m1_wr  input  1  1 = store, 0 = load
m0_size / m1_size  input  2  00 byte, 01 half, 10 word
m0_addr / m1_addr  input  ADDR_WIDTH  byte address
m0_wdata / m1_wdata  input  DATA_WIDTH  store data
m0_gnt / m1_gnt  output  1  one-cycle pulse: request latched
m0_done / m1_done  output  1  one-cycle pulse: access finished
m0_err / m1_err  output  1  valid with done: access rejected/aborted
rdata  output  DATA_WIDTH  load data; valid in the done cycle, held until the next done
m0_stall  output  1  m0_req | (owner==m0 && state!=IDLE)
bus_wd / bus_rd  output  1  write/read strobe to the bus controller
bus_size  output  2  latched size
bus_addr  output  ADDR_WIDTH  latched address
bus_wdata  output  DATA_WIDTH  latched store data
bus_rdata  input  DATA_WIDTH  bus read data
bus_ready  input  1  bus controller idle/ready
bus_busy  input  1  bus controller transaction in progress
arb_busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all gnt/done/err/strobes=0; rdata=0; bus_addr/size/wdata=0; last_owner=m1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any req=1 and bus_ready=1:
  - Pick the owner: single requester wins; if both request, the master != last_owner wins (round-robin).
  - Pulse owner gnt in this cycle; latch wr/size/addr/wdata.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11): go straight to RESP with err=1 and no bus strobe.
  - Otherwise go to ISSUE.
  - With bus_ready=0: stay in IDLE, no gnt.
- ISSUE: assert exactly one of bus_wd/bus_rd (registered) for one cycle; go to WAIT.
- WAIT: strobes=0. Minimum 1 cycle. When bus_ready=1 && bus_busy=0 is sampled, capture bus_rdata into rdata (loads only; stores leave rdata unchanged) and go to RESP.
- RESP: pulse owner done (err as set); update last_owner=owner; go to IDLE. A new grant can occur in the next cycle.
- Latency: req sampled in IDLE at cycle N -> gnt N, strobe N+1, earliest done N+3. Misaligned: done N+1.
- Requests arriving while state!=IDLE wait; req deassertion before gnt is legal and drops the request.
- bus_addr/size/wdata hold stable from ISSUE through RESP.
- Async reset mid-transaction drops strobes immediately, discards the access, and emits no done.

Optional Feature:
RISCUIN_ARB_TIMEOUT_EN:
- Defined: WAIT-cycle counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering WAIT. When it reaches TIMEOUT_CYCLES, go to RESP with err=1 and rdata unchanged.
- Undefined: no counter; WAIT persists indefinitely; err only from misalignment.

Test Plan:
- After reset, m0 load word addr 0x100, bus returns 0xDEADBEEF with busy 1 cycle -> m0_gnt cycle N, bus_rd N+1 only, m0_done N+4, rdata=0xDEADBEEF, m0_err=0.
- m0 and m1 request together, back-to-back, three times -> grant order m0, m1, m0; no overlapping strobes.
- m1 store half addr 0x203 -> m1_done one cycle after gnt with m1_err=1; bus_wd never asserted.
- bus_ready=0 for 5 cycles with m0_req=1 -> no gnt, m0_stall=1; gnt in the first cycle bus_ready=1.
- rst asserted low during WAIT -> strobes/done drop asynchronously; after release, state IDLE and m0 wins the next tie.
- With RISCUIN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_busy stuck 1 -> done with err=1 exactly 4 cycles after entering WAIT; without the macro, no done.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master load/store arbiter in front of the single data bus controller.
// Optional WAIT-state timeout is enabled by defining RISCUIN_ARB_TIMEOUT_EN.
module data_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [1:0]            m0_size,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic                  m0_stall,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [1:0]            m1_size,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_wd,
    output logic                  bus_rd,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ready,
    input  logic                  bus_busy,
    output logic                  arb_busy
);

    // state    | meaning
    // ST_IDLE  | no access owned; arbitrate when bus_ready
    // ST_ISSUE | one-cycle wd/rd strobe to the bus controller
    // ST_WAIT  | wait for bus_ready && !bus_busy
    // ST_RESP  | done/err pulse to the owner; rotate priority
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;          // 1 = m1
    logic                  last_owner_q, last_owner_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  bus_wd_q, bus_wd_d;
    logic                  bus_rd_q, bus_rd_d;

    logic                  any_req;
    logic                  pick_m1;
    logic                  grant;
    logic                  sel_wr;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_misaligned;

`ifdef RISCUIN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Tie goes to whichever master did not own the previous access.
    assign any_req   = m0_req | m1_req;
    assign pick_m1   = m1_req & (~m0_req | ~last_owner_q);
    assign grant     = (state_q == ST_IDLE) & any_req & bus_ready & rst;
    assign sel_wr    = pick_m1 ? m1_wr    : m0_wr;
    assign sel_size  = pick_m1 ? m1_size  : m0_size;
    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

    always_comb begin
        sel_misaligned = 1'b0;
        case (sel_size)
            2'b01:   sel_misaligned = sel_addr[0];
            2'b10:   sel_misaligned = (sel_addr[1:0] != 2'b00);
            2'b11:   sel_misaligned = 1'b1;
            default: sel_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        err_d        = err_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        bus_wd_d     = 1'b0;
        bus_rd_d     = 1'b0;
`ifdef RISCUIN_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d = pick_m1;
                    wr_d    = sel_wr;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_misaligned;
                    if (sel_misaligned) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                        bus_wd_d = sel_wr;
                        bus_rd_d = ~sel_wr;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef RISCUIN_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (bus_ready && !bus_busy) begin
                    if (!wr_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = ST_RESP;
                end
`ifdef RISCUIN_ARB_TIMEOUT_EN
                // Counter reaches TIMEOUT_CYCLES on this edge: abort with err.
                else if (wait_cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bus_wd_q     <= 1'b0;
            bus_rd_q     <= 1'b0;
`ifdef RISCUIN_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            bus_wd_q     <= bus_wd_d;
            bus_rd_q     <= bus_rd_d;
`ifdef RISCUIN_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign m0_gnt    = grant & ~pick_m1;
    assign m1_gnt    = grant & pick_m1;
    assign m0_done   = (state_q == ST_RESP) & ~owner_q;
    assign m1_done   = (state_q == ST_RESP) & owner_q;
    assign m0_err    = m0_done & err_q;
    assign m1_err    = m1_done & err_q;
    assign m0_stall  = m0_req | (~owner_q & (state_q != ST_IDLE));
    assign arb_busy  = (state_q != ST_IDLE);
    assign rdata     = rdata_q;
    assign bus_wd    = bus_wd_q;
    assign bus_rd    = bus_rd_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter; inputs driven 2 ns after each rising
// edge, outputs checked 1 ns later. Honours RISCUIN_ARB_TIMEOUT_EN.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m0_stall;
    logic        m1_gnt, m1_done, m1_err;
    logic [31:0] rdata;
    logic        bus_wd, bus_rd;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready, bus_busy, arb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
        .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
        .rdata(rdata), .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .bus_busy(bus_busy), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        bus_ready = 1'b1; bus_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
        m0_size = 2'b10; m1_size = 2'b10; m0_addr = 32'h0; m1_addr = 32'h0;
        m0_wdata = 32'h0; m1_wdata = 32'h0;
        bus_rdata = 32'h0; bus_ready = 1'b1; bus_busy = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b expected 00", {m0_gnt, m1_gnt}); end
        n_checks++; if ({m0_done, m1_done, m0_err, m1_err} !== 4'b0) begin n_fail++; $display("FAIL reset_done_err got %b expected 0000", {m0_done, m1_done, m0_err, m1_err}); end
        n_checks++; if ({bus_wd, bus_rd, arb_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b expected 000", {bus_wd, bus_rd, arb_busy}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0", rdata); end
        n_checks++; if ({bus_addr, bus_wdata, bus_size} !== 66'h0) begin n_fail++; $display("FAIL reset_bus_regs got %h/%h/%b expected 0", bus_addr, bus_wdata, bus_size); end
        m0_req = 1'b0; m1_req = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_load_word();
        cyc();
        m0_req = 1'b1; m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'h100;
        bus_ready = 1'b1; bus_busy = 1'b0;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt, bus_rd} !== 3'b100) begin n_fail++; $display("FAIL load_gnt got %b expected 100", {m0_gnt, m1_gnt, bus_rd}); end
        cyc();
        m0_req = 1'b0; bus_ready = 1'b0; bus_busy = 1'b1;
        #1;
        n_checks++; if ({bus_rd, bus_wd} !== 2'b10) begin n_fail++; $display("FAIL load_strobe got %b expected 10", {bus_rd, bus_wd}); end
        n_checks++; if (bus_addr !== 32'h100 || bus_size !== 2'b10) begin n_fail++; $display("FAIL load_bus_addr got %h/%b expected 100/10", bus_addr, bus_size); end
        n_checks++; if (m0_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall got %b expected 1", m0_stall); end
        cyc();
        #1;
        n_checks++; if ({bus_rd, m0_done} !== 2'b00) begin n_fail++; $display("FAIL load_wait1 got %b expected 00", {bus_rd, m0_done}); end
        cyc();
        bus_ready = 1'b1; bus_busy = 1'b0; bus_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (m0_done !== 1'b0) begin n_fail++; $display("FAIL load_early_done got %b expected 0", m0_done); end
        cyc();
        bus_rdata = 32'h0;
        #1;
        n_checks++; if ({m0_done, m0_err, m1_done} !== 3'b100) begin n_fail++; $display("FAIL load_done got %b expected 100", {m0_done, m0_err, m1_done}); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got %h expected deadbeef", rdata); end
        cyc();
        #1;
        n_checks++; if ({m0_done, arb_busy} !== 2'b00 || rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_after got %b rdata %h expected 00 deadbeef", {m0_done, arb_busy}, rdata); end
    endtask

    task automatic test_back_to_back();
        logic m1_slot;
        logic [5:0] exp;
        do_reset();
        bus_rdata = 32'h1111_1111;
        m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'h10;
        m1_wr = 1'b1; m1_size = 2'b10; m1_addr = 32'h20; m1_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 0) begin m0_req = 1'b1; m1_req = 1'b1; end
            #1;
            m1_slot = ((i / 4) == 1);
            // {m0_gnt, m1_gnt, bus_rd, bus_wd, m0_done, m1_done}
            exp = {(i % 4 == 0) && !m1_slot, (i % 4 == 0) && m1_slot,
                   (i % 4 == 1) && !m1_slot, (i % 4 == 1) && m1_slot,
                   (i % 4 == 3) && !m1_slot, (i % 4 == 3) && m1_slot};
            n_checks++;
            if ({m0_gnt, m1_gnt, bus_rd, bus_wd, m0_done, m1_done} !== exp) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d got %b expected %b", i, {m0_gnt, m1_gnt, bus_rd, bus_wd, m0_done, m1_done}, exp);
            end
            if (i == 5) begin
                n_checks++; if (bus_addr !== 32'h20 || bus_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_store_bus got %h/%h expected 20/cafef00d", bus_addr, bus_wdata); end
            end
        end
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00 || rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_end got %b rdata %h expected 00 11111111", {m0_gnt, m1_gnt}, rdata); end
    endtask

    task automatic test_misaligned();
        cyc();
        m1_req = 1'b1; m1_wr = 1'b1; m1_size = 2'b01; m1_addr = 32'h203;
        #1;
        n_checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin n_fail++; $display("FAIL mis_gnt got %b expected 10", {m1_gnt, m0_gnt}); end
        cyc();
        m1_req = 1'b0;
        #1;
        n_checks++; if ({m1_done, m1_err, m0_done} !== 3'b110) begin n_fail++; $display("FAIL mis_done got %b expected 110", {m1_done, m1_err, m0_done}); end
        n_checks++; if ({bus_wd, bus_rd} !== 2'b00) begin n_fail++; $display("FAIL mis_strobe got %b expected 00", {bus_wd, bus_rd}); end
        cyc();
        #1;
        n_checks++; if ({m1_done, bus_wd, arb_busy} !== 3'b000 || rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL mis_after got %b rdata %h expected 000 11111111", {m1_done, bus_wd, arb_busy}, rdata); end
    endtask

    task automatic test_ready_stall();
        m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'h40;
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) m0_req = 1'b1;
            #1;
            n_checks++; if ({m0_gnt, m0_stall, arb_busy} !== 3'b010) begin n_fail++; $display("FAIL stall_cycle%0d got %b expected 010", i, {m0_gnt, m0_stall, arb_busy}); end
        end
        cyc();
        bus_ready = 1'b1;
        #1;
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt got %b expected 1", m0_gnt); end
        cyc();
        m0_req = 1'b0;
        #1;
        n_checks++; if (bus_rd !== 1'b1 || bus_addr !== 32'h40) begin n_fail++; $display("FAIL stall_issue got %b/%h expected 1/40", bus_rd, bus_addr); end
        cyc();
        bus_rdata = 32'h5555AAAA;
        cyc();
        #1;
        n_checks++; if (m0_done !== 1'b1 || rdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL stall_done got %b rdata %h expected 1 5555aaaa", m0_done, rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'h80;
        cyc();
        m0_req = 1'b1;
        #1;
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt got %b expected 1", m0_gnt); end
        cyc();
        m0_req = 1'b0; bus_ready = 1'b0; bus_busy = 1'b1;
        #1;
        n_checks++; if (bus_rd !== 1'b1) begin n_fail++; $display("FAIL rmid_issue got %b expected 1", bus_rd); end
        cyc();
        #1;
        n_checks++; if (arb_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_wait got %b expected 1", arb_busy); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({arb_busy, bus_rd, bus_wd, m0_done, m0_stall} !== 5'b0) begin n_fail++; $display("FAIL rmid_async got %b expected 00000", {arb_busy, bus_rd, bus_wd, m0_done, m0_stall}); end
        n_checks++; if (bus_addr !== 32'h0 || rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_regs got %h/%h expected 0/0", bus_addr, rdata); end
        @(posedge clk);
        #2 rst = 1'b1; bus_ready = 1'b1; bus_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            n_checks++; if ({m0_done, m1_done, arb_busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_quiet%0d got %b expected 000", i, {m0_done, m1_done, arb_busy}); end
        end
        cyc();
        m0_req = 1'b1; m1_req = 1'b1; m1_size = 2'b10; m1_addr = 32'h20;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rmid_tie got %b expected 10", {m0_gnt, m1_gnt}); end
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();
        cyc();
        #1;
        n_checks++; if (m0_done !== 1'b1 || rdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL rmid_done got %b rdata %h expected 1 5555aaaa", m0_done, rdata); end
        cyc();
    endtask

    task automatic test_timeout();
        m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'hC0;
        bus_ready = 1'b1; bus_busy = 1'b0;
        cyc();
        m0_req = 1'b1;
        #1;
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt got %b expected 1", m0_gnt); end
        cyc();
        m0_req = 1'b0; bus_busy = 1'b1; bus_rdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            n_checks++; if (m0_done !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d got %b expected 0", k, m0_done); end
        end
`ifdef RISCUIN_ARB_TIMEOUT_EN
        cyc();
        #1;
        n_checks++; if ({m0_done, m0_err} !== 2'b11) begin n_fail++; $display("FAIL to_abort got %b expected 11", {m0_done, m0_err}); end
        n_checks++; if (rdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL to_rdata got %h expected 5555aaaa", rdata); end
        cyc();
        bus_busy = 1'b0;
        #1;
        n_checks++; if ({arb_busy, m0_done} !== 2'b00) begin n_fail++; $display("FAIL to_after got %b expected 00", {arb_busy, m0_done}); end
`else
        for (int k = 0; k < 10; k++) begin
            cyc();
            #1;
            n_checks++; if ({m0_done, arb_busy} !== 2'b01) begin n_fail++; $display("FAIL to_stuck%0d got %b expected 01", k, {m0_done, arb_busy}); end
        end
        bus_busy = 1'b0;
        cyc();
        #1;
        n_checks++; if ({m0_done, m0_err} !== 2'b10 || rdata !== 32'h12345678) begin n_fail++; $display("FAIL to_release got %b rdata %h expected 10 12345678", {m0_done, m0_err}, rdata); end
`endif
        cyc();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_back_to_back();
        test_misaligned();
        test_ready_stall();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
